// File: rtl/clint_pkg.sv
// clint_pkg: shared definitions for the core-local interruptor.
//   - register offsets relative to the CLINT base address
//   - responder FSM state encoding
//   - request/response record types, also used by the bus arbiter
//   - byte-strobe merge helper used by every 64-bit store path
package clint_pkg;

    localparam logic [63:0] CLINT_MSIP     = 64'h0000_0000_0000_0000;
    localparam logic [63:0] CLINT_MTIMECMP = 64'h0000_0000_0000_4000;
    localparam logic [63:0] CLINT_MTIME    = 64'h0000_0000_0000_BFF8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } clint_state_e;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic        write;
        logic [7:0]  strobe;
        logic [63:0] data;
    } clint_req_t;

    typedef struct packed {
        logic        ready;
        logic [63:0] data;
        logic        err;
    } clint_resp_t;

    // Bytes whose strobe bit is clear keep their old value.
    function automatic logic [63:0] strobe_merge(input logic [63:0] old_val,
                                                 input logic [63:0] new_val,
                                                 input logic [7:0]  strobe);
        logic [63:0] merged;
        for (int i = 0; i < 8; i++) begin
            merged[i*8 +: 8] = strobe[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/clint_timer.sv
// clint_timer: machine timer block.
//   Holds the tick prescaler, mtime, mtimecmp and the registered compare
//   that produces the timer interrupt.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_mtime_we          store to mtime this cycle (byte-merged with i_wstrb)
//   i_mtimecmp_we       store to mtimecmp this cycle (byte-merged with i_wstrb)
//   i_wstrb, i_wdata    store byte enables and data
//   o_mtime, o_mtimecmp current register values (for the read mux)
//   o_trint             mtime >= mtimecmp, from the previous cycle's registers
module clint_timer
    import clint_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_mtime_we,
    input  logic        i_mtimecmp_we,
    input  logic [7:0]  i_wstrb,
    input  logic [63:0] i_wdata,
    output logic [63:0] o_mtime,
    output logic [63:0] o_mtimecmp,
    output logic        o_trint
);

    localparam int             CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  TC = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_tick_cnt;
    logic [63:0]   r_mtime;
    logic [63:0]   r_mtimecmp;
    logic          r_trint;
    logic          w_tick;

    // mtime advances on the cycle the prescaler wraps back to 0.
    assign w_tick = (r_tick_cnt == TC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_mtime    <= '0;
            r_mtimecmp <= '1;
            r_trint    <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CW'(1);

            // A store beats a coincident tick; the tick is dropped and the
            // un-strobed bytes come from the pre-increment value.
            if (i_mtime_we) begin
                r_mtime <= strobe_merge(r_mtime, i_wdata, i_wstrb);
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end

            if (i_mtimecmp_we) begin
                r_mtimecmp <= strobe_merge(r_mtimecmp, i_wdata, i_wstrb);
            end

            r_trint <= (r_mtime >= r_mtimecmp);
        end
    end

    assign o_mtime    = r_mtime;
    assign o_mtimecmp = r_mtimecmp;
    assign o_trint    = r_trint;

endmodule

// File: rtl/clint.sv
// clint: core-local interruptor, memory-mapped responder on the uncached
// data bus. Owns msip and (through clint_timer) mtime/mtimecmp, and drives
// the timer and software interrupt levels into the CSR unit.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   req_*               single-outstanding request (valid/addr/write/strobe/data)
//   resp_ready          one-cycle completion pulse, one cycle after acceptance
//   resp_data, resp_err load data / unmapped-offset flag, zero outside resp_ready
//   trint, swint        timer and software interrupt pending levels
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting; a valid request is accepted, written or read here
// ST_RESP | resp_ready pulse with captured data/err, then back to idle
module clint
    import clint_pkg::*;
#(
    parameter logic [63:0] BASE     = 64'h0000_0000_0200_0000,
    parameter int          TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [63:0] req_addr,
    input  logic        req_write,
    input  logic [7:0]  req_strobe,
    input  logic [63:0] req_data,
    output logic        resp_ready,
    output logic [63:0] resp_data,
    output logic        resp_err,
    output logic        trint,
    output logic        swint
);

    clint_state_e r_state;
    clint_state_e w_state_nxt;
    clint_req_t   w_req;
    clint_resp_t  w_resp;

    logic         r_msip;
    logic [63:0]  r_resp_data;
    logic         r_resp_err;

    logic [63:0]  w_offset;
    logic         w_hit_msip;
    logic         w_hit_mtimecmp;
    logic         w_hit_mtime;
    logic         w_unmapped;
    logic         w_accept;
    logic         w_msip_we;
    logic         w_mtime_we;
    logic         w_mtimecmp_we;
    logic [63:0]  w_rdata;
    logic [63:0]  w_mtime;
    logic [63:0]  w_mtimecmp;
    logic         w_trint;

    assign w_req = '{valid:  req_valid,
                     addr:   req_addr,
                     write:  req_write,
                     strobe: req_strobe,
                     data:   req_data};

    assign w_offset       = w_req.addr - BASE;
    assign w_hit_msip     = (w_offset == CLINT_MSIP);
    assign w_hit_mtimecmp = (w_offset == CLINT_MTIMECMP);
    assign w_hit_mtime    = (w_offset == CLINT_MTIME);
    assign w_unmapped     = !(w_hit_msip || w_hit_mtimecmp || w_hit_mtime);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req.valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_msip_we     = w_accept && w_req.write && w_hit_msip;
    assign w_mtime_we    = w_accept && w_req.write && w_hit_mtime;
    assign w_mtimecmp_we = w_accept && w_req.write && w_hit_mtimecmp;

    always_comb begin
        w_rdata = '0;
        if (w_hit_msip) begin
            w_rdata = {63'd0, r_msip};
        end else if (w_hit_mtimecmp) begin
            w_rdata = w_mtimecmp;
        end else if (w_hit_mtime) begin
            w_rdata = w_mtime;
        end
    end

    clint_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk           (clk),
        .rst_n         (reset),
        .i_mtime_we    (w_mtime_we),
        .i_mtimecmp_we (w_mtimecmp_we),
        .i_wstrb       (w_req.strobe),
        .i_wdata       (w_req.data),
        .o_mtime       (w_mtime),
        .o_mtimecmp    (w_mtimecmp),
        .o_trint       (w_trint)
    );

    // Response payload is captured at acceptance and cleared on every other
    // cycle, so data/err are zero whenever resp_ready is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_msip      <= 1'b0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_resp_data <= (w_accept && !w_req.write) ? w_rdata : '0;
            r_resp_err  <= w_accept && w_unmapped;
            if (w_msip_we && w_req.strobe[0]) begin
                r_msip <= w_req.data[0];
            end
        end
    end

    assign w_resp = '{ready: (r_state == ST_RESP),
                      data:  r_resp_data,
                      err:   r_resp_err};

    assign resp_ready = w_resp.ready;
    assign resp_data  = w_resp.data;
    assign resp_err   = w_resp.err;
    assign trint      = w_trint;
    assign swint      = r_msip;

endmodule

// File: tb/tb_clint.sv
// tb_clint: directed, table-driven bench for clint.
// dut1 runs with TICK_DIV=1, dut4 with TICK_DIV=4; they share the request
// address/data/strobe/write lines and have separate valid and reset inputs.
module tb_clint;
    import clint_pkg::*;

    localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset1, reset4;
    logic        req_valid1, req_valid4;
    logic [63:0] req_addr;
    logic        req_write;
    logic [7:0]  req_strobe;
    logic [63:0] req_data;

    logic        resp_ready1, resp_err1, trint1, swint1;
    logic [63:0] resp_data1;
    logic        resp_ready4, resp_err4, trint4, swint4;
    logic [63:0] resp_data4;

    clint #(.BASE(BASE), .TICK_DIV(1)) dut1 (
        .clk        (clk),
        .reset      (reset1),
        .req_valid  (req_valid1),
        .req_addr   (req_addr),
        .req_write  (req_write),
        .req_strobe (req_strobe),
        .req_data   (req_data),
        .resp_ready (resp_ready1),
        .resp_data  (resp_data1),
        .resp_err   (resp_err1),
        .trint      (trint1),
        .swint      (swint1)
    );

    clint #(.BASE(BASE), .TICK_DIV(4)) dut4 (
        .clk        (clk),
        .reset      (reset4),
        .req_valid  (req_valid4),
        .req_addr   (req_addr),
        .req_write  (req_write),
        .req_strobe (req_strobe),
        .req_data   (req_data),
        .resp_ready (resp_ready4),
        .resp_data  (resp_data4),
        .resp_err   (resp_err4),
        .trint      (trint4),
        .swint      (swint4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction. Called one time unit after a rising edge;
    // returns one time unit after the edge that ends the response cycle.
    // rd/err/sw/tr are sampled in the resp_ready cycle.
    task automatic bus(input bit sel, input logic wr, input logic [63:0] off,
                       input logic [7:0] strb, input logic [63:0] data,
                       output logic [63:0] rd, output logic err,
                       output logic sw, output logic tr);
        req_write  = wr;
        req_addr   = BASE + off;
        req_strobe = strb;
        req_data   = data;
        if (sel) req_valid4 = 1'b1;
        else     req_valid1 = 1'b1;
        @(posedge clk); #1;
        chk("resp_ready_pulse", {63'd0, sel ? resp_ready4 : resp_ready1}, 64'd1);
        rd  = sel ? resp_data4 : resp_data1;
        err = sel ? resp_err4  : resp_err1;
        sw  = sel ? swint4     : swint1;
        tr  = sel ? trint4     : trint1;
        req_valid1 = 1'b0;
        req_valid4 = 1'b0;
        @(posedge clk); #1;
        chk("resp_ready_drop", {63'd0, sel ? resp_ready4 : resp_ready1}, 64'd0);
        chk("resp_data_idle_zero", sel ? resp_data4 : resp_data1, 64'd0);
        chk("resp_err_idle_zero", {63'd0, sel ? resp_err4 : resp_err1}, 64'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [63:0] off;
        logic [7:0]  strb;
        logic [63:0] data;
        logic [63:0] exp_rd;
        logic        exp_err;
        logic        exp_sw;
    } vec_t;

    vec_t        vecs[19];
    logic [63:0] rd;
    logic        er, sw, tr;
    logic [63:0] exp4[5] = '{64'd2, 64'd2, 64'd3, 64'd3, 64'd4};

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        //           wr    offset          strb   data                      exp_rd                    err   sw
        vecs[0]  = '{1'b1, CLINT_MSIP,     8'h01, 64'h1,                    64'h0,                    1'b0, 1'b1};
        vecs[1]  = '{1'b0, CLINT_MSIP,     8'h00, 64'h0,                    64'h1,                    1'b0, 1'b1};
        vecs[2]  = '{1'b1, CLINT_MSIP,     8'h01, 64'h0,                    64'h0,                    1'b0, 1'b0};
        vecs[3]  = '{1'b0, CLINT_MSIP,     8'h00, 64'h0,                    64'h0,                    1'b0, 1'b0};
        vecs[4]  = '{1'b1, CLINT_MSIP,     8'hFE, ONES,                     64'h0,                    1'b0, 1'b0};
        vecs[5]  = '{1'b0, CLINT_MSIP,     8'h00, 64'h0,                    64'h0,                    1'b0, 1'b0};
        vecs[6]  = '{1'b1, CLINT_MSIP,     8'hFF, 64'hFFFF_FFFF,            64'h0,                    1'b0, 1'b1};
        vecs[7]  = '{1'b0, CLINT_MSIP,     8'h00, 64'h0,                    64'h1,                    1'b0, 1'b1};
        vecs[8]  = '{1'b1, CLINT_MSIP,     8'h01, 64'h0,                    64'h0,                    1'b0, 1'b0};
        vecs[9]  = '{1'b1, CLINT_MTIMECMP, 8'h0F, 64'h1234_5678,            64'h0,                    1'b0, 1'b0};
        vecs[10] = '{1'b0, CLINT_MTIMECMP, 8'h00, 64'h0,                    64'hFFFF_FFFF_1234_5678,  1'b0, 1'b0};
        vecs[11] = '{1'b1, CLINT_MTIMECMP, 8'hF0, 64'hAAAA_BBBB_0000_0000,  64'h0,                    1'b0, 1'b0};
        vecs[12] = '{1'b0, CLINT_MTIMECMP, 8'h00, 64'h0,                    64'hAAAA_BBBB_1234_5678,  1'b0, 1'b0};
        vecs[13] = '{1'b0, 64'h0100,       8'h00, 64'h0,                    64'h0,                    1'b1, 1'b0};
        vecs[14] = '{1'b1, 64'h0100,       8'hFF, ONES,                     64'h0,                    1'b1, 1'b0};
        vecs[15] = '{1'b0, 64'h0004,       8'h00, 64'h0,                    64'h0,                    1'b1, 1'b0};
        vecs[16] = '{1'b1, CLINT_MTIMECMP, 8'hFF, ONES,                     64'h0,                    1'b0, 1'b0};
        vecs[17] = '{1'b0, CLINT_MTIMECMP, 8'h00, 64'h0,                    ONES,                     1'b0, 1'b0};
        vecs[18] = '{1'b0, 64'hBFF0,       8'h00, 64'h0,                    64'h0,                    1'b1, 1'b0};

        reset1 = 1'b0; reset4 = 1'b0;
        req_valid1 = 1'b0; req_valid4 = 1'b0;
        req_addr = BASE; req_write = 1'b0; req_strobe = 8'h00; req_data = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_ready1", {63'd0, resp_ready1}, 64'd0);
        chk("rst_resp_data1",  resp_data1,           64'd0);
        chk("rst_resp_err1",   {63'd0, resp_err1},   64'd0);
        chk("rst_trint1",      {63'd0, trint1},      64'd0);
        chk("rst_swint1",      {63'd0, swint1},      64'd0);
        chk("rst_resp_ready4", {63'd0, resp_ready4}, 64'd0);
        chk("rst_trint4",      {63'd0, trint4},      64'd0);
        chk("rst_swint4",      {63'd0, swint4},      64'd0);
        reset1 = 1'b1;
        reset4 = 1'b1;

        // Idle 10 cycles, TICK_DIV=1: mtime sampled at acceptance is 10
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            chk("idle_trint", {63'd0, trint1}, 64'd0);
            chk("idle_swint", {63'd0, swint1}, 64'd0);
        end
        bus(1'b0, 1'b0, CLINT_MTIME, 8'h00, 64'h0, rd, er, sw, tr);
        chk("idle_mtime_read", rd, 64'd10);
        chk("idle_mtime_err", {63'd0, er}, 64'd0);

        // Register-map vectors
        chk("pre_msip_swint", {63'd0, swint1}, 64'd0);
        for (int i = 0; i < 19; i++) begin
            bus(1'b0, vecs[i].wr, vecs[i].off, vecs[i].strb, vecs[i].data, rd, er, sw, tr);
            if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i),   {63'd0, er}, {63'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d_swint", i), {63'd0, sw}, {63'd0, vecs[i].exp_sw});
            chk($sformatf("vec%0d_trint", i), {63'd0, tr}, 64'd0);
        end

        // Compare timing: mtime=5 at edge a, mtimecmp=20 at a+2,
        // mtime reaches 20 after a+15, trint rises after a+16
        bus(1'b0, 1'b1, CLINT_MTIME,    8'hFF, 64'd5,  rd, er, sw, tr);
        bus(1'b0, 1'b1, CLINT_MTIMECMP, 8'hFF, 64'd20, rd, er, sw, tr);
        chk("cmp_store_trint", {63'd0, tr}, 64'd0);
        for (int j = 1; j <= 13; j++) begin
            @(posedge clk); #1;
            chk($sformatf("cmp_rise_j%0d", j), {63'd0, trint1}, {63'd0, (j == 13)});
        end
        bus(1'b0, 1'b0, CLINT_MTIME, 8'h00, 64'h0, rd, er, sw, tr);
        chk("cmp_mtime_after_rise", rd, 64'd21);
        chk("cmp_trint_held", {63'd0, tr}, 64'd1);
        bus(1'b0, 1'b1, CLINT_MTIMECMP, 8'hFF, ONES, rd, er, sw, tr);
        chk("cmp_clear_n1_still_high", {63'd0, tr}, 64'd1);
        chk("cmp_clear_n2_low", {63'd0, trint1}, 64'd0);

        // 64-bit wrap with mtimecmp = 0
        bus(1'b0, 1'b1, CLINT_MTIMECMP, 8'hFF, 64'd0, rd, er, sw, tr);
        chk("wrap_cmp0_trint", {63'd0, trint1}, 64'd1);
        bus(1'b0, 1'b1, CLINT_MTIME, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE, rd, er, sw, tr);
        chk("wrap_store_trint", {63'd0, tr}, 64'd1);
        @(posedge clk); #1;
        chk("wrap_pre_trint", {63'd0, trint1}, 64'd1);
        bus(1'b0, 1'b0, CLINT_MTIME, 8'h00, 64'h0, rd, er, sw, tr);
        chk("wrap_mtime_zero", rd, 64'd0);
        chk("wrap_trint_across", {63'd0, tr}, 64'd1);
        chk("wrap_post_trint", {63'd0, trint1}, 64'd1);
        bus(1'b0, 1'b1, CLINT_MTIMECMP, 8'hFF, ONES, rd, er, sw, tr);

        // Partial mtime store races a tick: low byte from the store,
        // the rest from the pre-increment value 0x101, tick lost
        bus(1'b0, 1'b1, CLINT_MTIME, 8'hFF, 64'h100, rd, er, sw, tr);
        bus(1'b0, 1'b1, CLINT_MTIME, 8'h01, 64'hAB,  rd, er, sw, tr);
        bus(1'b0, 1'b0, CLINT_MTIME, 8'h00, 64'h0,   rd, er, sw, tr);
        chk("partial_mtime_merge", rd, 64'h1AC);

        // TICK_DIV=4 and reset asserted during RESP
        bus(1'b1, 1'b1, CLINT_MSIP, 8'h01, 64'h1, rd, er, sw, tr);
        chk("div4_msip_set", {63'd0, sw}, 64'd1);
        req_write = 1'b1; req_addr = BASE + CLINT_MTIME; req_strobe = 8'hFF; req_data = 64'h1234;
        req_valid4 = 1'b1;
        @(posedge clk); #1;
        chk("midrst_in_resp", {63'd0, resp_ready4}, 64'd1);
        reset4 = 1'b0;
        req_valid4 = 1'b0;
        #1;
        chk("midrst_resp_ready", {63'd0, resp_ready4}, 64'd0);
        chk("midrst_swint",      {63'd0, swint4},      64'd0);
        chk("midrst_trint",      {63'd0, trint4},      64'd0);
        chk("midrst_resp_data",  resp_data4,           64'd0);
        @(posedge clk); #1;
        chk("midrst_hold_ready", {63'd0, resp_ready4}, 64'd0);
        @(posedge clk); #1;
        reset4 = 1'b1;
        @(posedge clk); #1;
        chk("midrst_no_response", {63'd0, resp_ready4}, 64'd0);
        repeat (8) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            bus(1'b1, 1'b0, CLINT_MTIME, 8'h00, 64'h0, rd, er, sw, tr);
            chk($sformatf("div4_mtime_%0d", k), rd, exp4[k]);
        end
        bus(1'b1, 1'b0, CLINT_MTIMECMP, 8'h00, 64'h0, rd, er, sw, tr);
        chk("div4_mtimecmp_reset", rd, ONES);
        bus(1'b1, 1'b0, CLINT_MSIP, 8'h00, 64'h0, rd, er, sw, tr);
        chk("div4_msip_reset", rd, 64'd0);
        chk("div4_swint_reset", {63'd0, sw}, 64'd0);
        chk("div4_trint_low", {63'd0, tr}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clint.md
# clint

Core-local interruptor: a memory-mapped responder that owns the machine timer (`mtime`/`mtimecmp`) and the machine software-interrupt bit (`msip`), and drives the `trint` and `swint` level inputs of the CSR unit. It sits on the uncached data-bus side of the memory stage. Loads and stores from the core reach it through a single-outstanding request/response handshake. External interrupts (`exint`) are not generated here.

## Interface
- `BASE`, 64'h0200_0000: base address; decode uses offset = `req_addr - BASE`.
- `TICK_DIV`, 1: core clocks per `mtime` increment; must be ≥1.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present; held until `resp_ready`.
- `req_addr` in 64: byte address, 8-byte aligned for 64-bit registers.
- `req_write` in 1: 1 = store, 0 = load.
- `req_strobe` in 8: byte enables for stores.
- `req_data` in 64: store data, lane-aligned to `req_addr[2:0]`.
- `resp_ready` out 1: one-cycle completion pulse.
- `resp_data` out 64: load data, valid while `resp_ready`=1.
- `resp_err` out 1: unmapped offset, valid while `resp_ready`=1.
- `trint` out 1: timer interrupt pending (mtime ≥ mtimecmp).
- `swint` out 1: software interrupt pending (`msip[0]`).

## Operation
- Register map (offsets):
  - `0x0000` msip: 32-bit; only bit 0 is writable; other bits read 0.
  - `0x4000` mtimecmp: 64-bit.
  - `0xBFF8` mtime: 64-bit.
  - Any other offset: loads return 0 with `resp_err`=1; stores are dropped with `resp_err`=1.
- Stores merge by byte using `req_strobe`. For msip, only lane 0 bit 0 matters.
- FSM has two states:
  - IDLE: when `req_valid`=1, latch the request, perform the write or capture the read data, and go to RESP.
  - RESP: drive `resp_ready`=1, then go to IDLE unconditionally.
- The requester must deassert `req_valid` (or present a new request) in the cycle after `resp_ready`. A still-asserted `req_valid` in IDLE is treated as a new request.
- Prescaler: `tick_cnt` counts 0..`TICK_DIV`-1. When it wraps to 0, `mtime` += 1; 64-bit wrap from all-ones to 0 is allowed.
- A store to mtime in the same cycle as a tick: the store wins and the tick is lost. Per-byte partial stores keep the un-strobed bytes from the pre-increment value.
- The prescaler is not reset by mtime stores.
- `trint` is registered: it reflects `mtime >= mtimecmp` (unsigned) evaluated on the register values of the previous cycle.
- `swint` = `msip[0]` (register output).
- Reset values:
  - mtime = 0, mtimecmp = all-ones, msip = 0, tick_cnt = 0.
  - FSM = IDLE.
  - `resp_ready` = 0, `resp_data` = 0, `resp_err` = 0, `trint` = 0, `swint` = 0.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately, no response is issued, and a partially issued store has no effect beyond what was already registered.

## Timing
- Latency is request accepted in cycle N → `resp_ready` in cycle N+1. Throughput is at most one request per 2 cycles.
- Read data is captured at acceptance (cycle N), so a tick in cycle N+1 does not alter it.
- Store effects are visible from cycle N+1:
  - `swint` changes in N+1.
  - `trint` reflects a new mtime or mtimecmp value from N+2.
- Timer latency: the first cycle with `mtime == mtimecmp` is cycle T, and `trint` rises in T+1. `trint` stays high until mtimecmp is raised above mtime or mtime wraps.
- `resp_data` and `resp_err` are held at 0 when `resp_ready`=0.

## Structure
- A shared `clint_pkg` holds:
  - offset constants `CLINT_MSIP`, `CLINT_MTIMECMP`, `CLINT_MTIME`;
  - the FSM state enum;
  - the request/response struct types, shared with the bus arbiter.
- One sub-module, `clint_timer`, contains the prescaler, mtime, mtimecmp, and the compare register. It has strobe-merge write ports and produces `trint`.
- The top level holds the FSM, address decode, msip, and the read mux.

## Test plan
- Reset then idle with `TICK_DIV`=1 → after 10 cycles, a load of `0xBFF8` returns 10 or 11 (fixed by the sampling cycle); `trint`=0 and `swint`=0 throughout.
- Store 1 to msip, then store 0 → `swint` rises the cycle after the first `resp_ready` and falls after the second; a load of msip returns 1 and then 0.
- Store mtimecmp = 20 with mtime ≈ 5 → `trint` rises exactly one cycle after mtime reads 20; storing mtimecmp = all-ones clears `trint` two cycles after acceptance.
- Store mtime = 64'hFFFF_FFFF_FFFF_FFFE with `TICK_DIV`=1 → mtime wraps to 0 two ticks later. With mtimecmp = 0, `trint` stays 1 across the wrap.
- Partial store: strobe 8'h0F, data 32'h1234_5678 to mtimecmp (reset all-ones) → a read returns 64'hFFFF_FFFF_1234_5678. A load of offset `0x0100` returns 0 with `resp_err`=1.
- `TICK_DIV`=4, plus reset deasserted and reasserted while in RESP → mtime advances once per 4 cycles; during reset `resp_ready`=0, with no response and all registers at their reset values.
